sram_ctrl: RTL
==============

Name: sram_ctrl

Overview:
Sequencer between the CPU-side memory request (MAR/MDR path and the I/O controller) and the external 1Mx16 asynchronous SRAM. It turns a single-cycle read/write request into correctly ordered active-low CE/OE/WE/UB/LB strobes with programmable wait states. It drives the tristate output-enable, captures read data and returns a one-cycle acknowledge, so the control FSM no longer hard-codes memory wait states.

Parameters:
WAIT_CYCLES, 2, cycles the OE/WE strobe stays active (legal 1..15)
ADDR_W, 20, SRAM address width
DATA_W, 16, SRAM data width

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
req  in  1  request strobe; sampled only when ready=1
we_req  in  1  1=write, 0=read; sampled with req
addr  in  ADDR_W  request address; sampled with req
wdata  in  DATA_W  write data; sampled with req
be  in  2  byte enables, active-high, [1]=upper, [0]=lower; sampled with req
ready  out  1  block can accept req this cycle
ack  out  1  one-cycle pulse: operation complete
rdata  out  DATA_W  read data, valid with ack, held until the next read completes
ADDR  out  ADDR_W  registered SRAM address
Data_to_SRAM  out  DATA_W  registered write data
Data_from_SRAM  in  DATA_W  data from the tristate buffer
drive_en  out  1  tristate output enable, 1=drive bus
Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB  out  1 each  SRAM strobes, active-low

Behaviour:
- Reset is asynchronous, active-high. While it is asserted and after release: state IDLE, ready=1, ack=0, rdata=0, ADDR=0, Data_to_SRAM=0, drive_en=0, all Mem_* =1. Reset mid-operation aborts the access immediately; the aborted operation produces no ack.
- States:
  - IDLE: ready=1, all strobes high. req at edge E0 latches addr, wdata, be and we_req. Next state is RD (counter=WAIT_CYCLES-1) or WSETUP.
  - RD: CE=0, OE=0, UB/LB = ~be_q. Decrements once per edge. At the edge where counter==0, rdata <= Data_from_SRAM and the FSM goes to DONE. RD lasts WAIT_CYCLES cycles.
  - WSETUP: 1 cycle. CE=0, WE=1, OE=1, drive_en=1, UB/LB = ~be_q. Goes to WR (counter=WAIT_CYCLES-1).
  - WR: CE=0, WE=0, drive_en=1. Lasts WAIT_CYCLES cycles, then WHOLD.
  - WHOLD: 1 cycle. CE=0, WE=1, drive_en=1 (data hold). Goes to DONE.
  - DONE: 1 cycle. ack=1, strobes high, drive_en=0. Goes to IDLE.
- Latency: read ack is high in the cycle after edge E0+WAIT_CYCLES. Write ack is high in the cycle after edge E0+WAIT_CYCLES+2.
- OE and WE are never low in the same cycle. drive_en=1 only in WSETUP/WR/WHOLD.
- req while ready=0 is ignored: no queueing, no error.
- be=2'b00: sequence runs normally with UB=LB=1. Ack still issued; rdata captures bus value.
- ADDR and Data_to_SRAM hold their last latched values when idle.

Optional Feature:
SRAM_CTRL_B2B_EN
- Defined: ready=1 in both IDLE and DONE. A req in DONE is accepted at that edge and goes directly to RD/WSETUP. ack for the prior operation is still pulsed. Back-to-back read throughput is WAIT_CYCLES+1 cycles per access.
- Undefined: ready=1 only in IDLE. Minimum spacing is WAIT_CYCLES+2 cycles for reads and WAIT_CYCLES+4 for writes.

Decomposition:
- Package sram_ctrl_pkg: state enum (IDLE, RD, WSETUP, WR, WHOLD, DONE), default widths, the WAIT_CYCLES default, and a 4-bit counter width constant.
- Natural sub-module sram_wait_cnt: loadable down-counter with a zero flag, reused for the RD and WR phases.
- Elaboration-time check that 1 <= WAIT_CYCLES <= 15.

Test Plan:
- Read, WAIT_CYCLES=2: req, we_req=0, addr=20'h00012 at E0, SRAM model returns 16'hBEEF -> CE/OE low for 2 cycles; ack and rdata=16'hBEEF in the cycle after E0+2; ready low from E0 to ack.
- Write, WAIT_CYCLES=2: addr=20'h0ABCD, wdata=16'h1234, be=2'b11 -> WE low for exactly 2 cycles; drive_en high 4 cycles with Data_to_SRAM=16'h1234; ack in the cycle after E0+4; model memory holds 16'h1234.
- Byte write, be=2'b01, wdata=16'hAA55 -> Mem_LB=0, Mem_UB=1 throughout the access; only the lower byte of the model changes.
- req pulses during RD/WR (without the macro) are ignored -> exactly one ack per accepted req; a second req issued 1 cycle after ack is accepted.
- Assert Reset in the second WR cycle -> Mem_WE, Mem_CE high and drive_en=0 before the next edge; no ack; ready=1 after release.
- With SRAM_CTRL_B2B_EN and WAIT_CYCLES=1: reads to 20'h1 then 20'h2 with req held -> acks spaced 2 cycles apart with correct rdata each.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and defaults for the SRAM access sequencer
package sram_ctrl_pkg;

    localparam int DEF_ADDR_W      = 20;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WSETUP = 3'd2,
        WR     = 3'd3,
        WHOLD  = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/sram_wait_cnt.sv
// rtl/sram_wait_cnt.sv - loadable wait-state down-counter with zero flag
module sram_wait_cnt
    import sram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - async SRAM strobe sequencer with programmable wait states
// Optional macro SRAM_CTRL_B2B_EN: accept a new request in the DONE cycle.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic              we_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        be,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic              drive_en,
    output logic              Mem_CE,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic              Mem_UB,
    output logic              Mem_LB
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("sram_ctrl: WAIT_CYCLES must be within 1..15");
    end

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [1:0] be_q;
    logic       accept;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;

    assign accept = req && ready;

    sram_wait_cnt u_wait_cnt (
        .clk      (Clk),
        .rst      (Reset),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = we_req ? WSETUP : RD;
                    cnt_load   = !we_req;
                end else begin
                    state_next = IDLE;
                end
            end
            RD: begin
                if (cnt_zero) begin
                    state_next = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WSETUP: begin
                state_next = WR;
                cnt_load   = 1'b1;
            end
            WR: begin
                if (cnt_zero) begin
                    state_next = WHOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WHOLD:   state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are decoded straight from the state register so an async reset releases them at once.
    always_comb begin
        ready    = 1'b0;
        ack      = 1'b0;
        drive_en = 1'b0;
        Mem_CE   = 1'b1;
        Mem_OE   = 1'b1;
        Mem_WE   = 1'b1;
        Mem_UB   = 1'b1;
        Mem_LB   = 1'b1;
        case (state)
            IDLE: ready = 1'b1;
            RD: begin
                Mem_CE = 1'b0;
                Mem_OE = 1'b0;
                Mem_UB = ~be_q[1];
                Mem_LB = ~be_q[0];
            end
            WSETUP, WHOLD: begin
                Mem_CE   = 1'b0;
                drive_en = 1'b1;
                Mem_UB   = ~be_q[1];
                Mem_LB   = ~be_q[0];
            end
            WR: begin
                Mem_CE   = 1'b0;
                Mem_WE   = 1'b0;
                drive_en = 1'b1;
                Mem_UB   = ~be_q[1];
                Mem_LB   = ~be_q[0];
            end
            DONE: begin
                ack = 1'b1;
`ifdef SRAM_CTRL_B2B_EN
                ready = 1'b1;
`else
                ready = 1'b0;
`endif
            end
            default: ready = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ADDR         <= '0;
            Data_to_SRAM <= '0;
            be_q         <= '0;
        end else if (accept) begin
            ADDR         <= addr;
            Data_to_SRAM <= wdata;
            be_q         <= be;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rdata <= '0;
        end else if (state == RD && cnt_zero) begin
            rdata <= Data_from_SRAM;
        end
    end

endmodule
